mem_access_ctrl: RTL

- Processor-side initiator for the 64x32 word memory: turns single read/write requests from the datapath (address source, RM write data) into the memory's address/enable/data signalling.
- Waits for MFC and returns read data toward MUX-Y/RY.
- Encodes the write enable in address bit 6, holding it only while the address and data are stable.
- Guards against a stuck MFC with a timeout.

---
 rtl/mem_access_pkg.sv | 16 +
 rtl/mfc_timeout_counter.sv | 19 +
 rtl/mem_access_ctrl.sv | 93 +++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: state encoding, width defaults and helpers shared by mem_access_ctrl
// Contents: state_t (IDLE/SETUP/WAIT/DONE), ADDR_W, DATA_W, STAT_W, sat_inc()
package mem_access_pkg;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
    localparam int STAT_W = 16;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return &v ? v : v + {{(STAT_W-1){1'b0}}, 1'b1};
    endfunction
endpackage

// File: rtl/mfc_timeout_counter.sv
// mfc_timeout_counter: 8-bit WAIT-cycle counter flagging the last allowed cycle before an MFC timeout
// Ports: clk, rst_n (async active-low), clr (synchronous clear, wins over en),
//        en (count up), expired (count == MFC_TIMEOUT-1)
module mfc_timeout_counter #(
    parameter int MFC_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam logic [7:0] LAST = 8'(MFC_TIMEOUT - 1);
    logic [7:0] cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else cnt <= clr ? '0 : en ? cnt + 8'd1 : cnt;
    assign expired = cnt == LAST;
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-request initiator for a 64x32 level-sensitive memory with MFC handshake and timeout
// Ports: clk, rst_n (async active-low)
//        req_valid/req_ready/req_write/req_addr/req_wdata - datapath request (ready only in IDLE)
//        mem_address ([ADDR_W] = write enable), mem_wdata, mem_rdata, mem_mfc - memory side
//        rsp_valid (1-cycle pulse), rsp_rdata (last read data), rsp_err (MFC timeout), busy
//        stat_reads/stat_writes/stat_timeouts - saturating counters, present only with MEM_ACCESS_STATS_EN
module mem_access_ctrl #(
    parameter int ADDR_W      = mem_access_pkg::ADDR_W,
    parameter int DATA_W      = mem_access_pkg::DATA_W,
    parameter int MFC_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [ADDR_W:0]   mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_mfc,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
`ifdef MEM_ACCESS_STATS_EN
    ,
    output logic [mem_access_pkg::STAT_W-1:0] stat_reads,
    output logic [mem_access_pkg::STAT_W-1:0] stat_writes,
    output logic [mem_access_pkg::STAT_W-1:0] stat_timeouts
`endif
);
    import mem_access_pkg::*;
    state_t state, state_nx;
    logic   wr_q, expired, wait_end;
    assign wait_end  = mem_mfc || expired;
    assign req_ready = state == IDLE;
    mfc_timeout_counter #(.MFC_TIMEOUT(MFC_TIMEOUT)) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state != WAIT),
        .en      (state == WAIT),
        .expired (expired)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE)  ? (req_valid ? SETUP : IDLE) :
                   (state == SETUP) ? WAIT :
                   (state == WAIT)  ? (wait_end ? DONE : WAIT) : IDLE;
    end
    // The enable bit only rises one cycle after address/data settle and drops
    // before IDLE can load a new address, so the memory never sees a transient.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_q        <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            rsp_rdata   <= '0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            busy      <= state_nx != IDLE;
            rsp_valid <= state == WAIT && wait_end;
            rsp_err   <= state == WAIT && !mem_mfc && expired;
            if (state == IDLE && req_valid) begin
                wr_q        <= req_write;
                mem_address <= {1'b0, req_addr};
                mem_wdata   <= req_wdata;
            end
            if (state == SETUP) mem_address[ADDR_W] <= wr_q;
            if (state == WAIT && wait_end) begin
                mem_address[ADDR_W] <= 1'b0;
                if (mem_mfc && !wr_q) rsp_rdata <= mem_rdata;
            end
        end
`ifdef MEM_ACCESS_STATS_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            stat_reads    <= '0;
            stat_writes   <= '0;
            stat_timeouts <= '0;
        end else if (rsp_valid) begin
            if (rsp_err) stat_timeouts <= sat_inc(stat_timeouts);
            else if (wr_q) stat_writes <= sat_inc(stat_writes);
            else stat_reads <= sat_inc(stat_reads);
        end
`endif
endmodule
